// File: rtl/cache_perf_collector.sv
// Cache performance event collector: registers per-cycle handshake/strobe vectors,
// then accumulates their population counts into eight wrap-around counters.
module cache_perf_collector #(
    parameter int NUM_REQS      = 4,
    parameter int NUM_BANKS     = 2,
    parameter int PERF_CTR_BITS = 44
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     enable,
    input  logic                     clear,
    input  logic [NUM_REQS-1:0]      core_req_valid,
    input  logic [NUM_REQS-1:0]      core_req_ready,
    input  logic [NUM_REQS-1:0]      core_req_rw,
    input  logic [NUM_REQS-1:0]      core_rsp_valid,
    input  logic [NUM_REQS-1:0]      core_rsp_ready,
    input  logic [NUM_BANKS-1:0]     bank_miss_valid,
    input  logic [NUM_BANKS-1:0]     bank_miss_rw,
    input  logic [NUM_BANKS-1:0]     bank_stall,
    input  logic [NUM_BANKS-1:0]     mshr_stall,
    input  logic                     mem_req_valid,
    input  logic                     mem_req_ready,
    output logic [PERF_CTR_BITS-1:0] reads,
    output logic [PERF_CTR_BITS-1:0] writes,
    output logic [PERF_CTR_BITS-1:0] read_misses,
    output logic [PERF_CTR_BITS-1:0] write_misses,
    output logic [PERF_CTR_BITS-1:0] bank_stalls,
    output logic [PERF_CTR_BITS-1:0] mshr_stalls,
    output logic [PERF_CTR_BITS-1:0] mem_stalls,
    output logic [PERF_CTR_BITS-1:0] crsp_stalls
);

    localparam int RC_W = $clog2(NUM_REQS + 1);
    localparam int BC_W = $clog2(NUM_BANKS + 1);

    function automatic logic [RC_W-1:0] pop_req(input logic [NUM_REQS-1:0] v);
        logic [RC_W-1:0] c;
        c = '0;
        for (int i = 0; i < NUM_REQS; i++) begin
            c = c + RC_W'(v[i]);
        end
        return c;
    endfunction

    function automatic logic [BC_W-1:0] pop_bank(input logic [NUM_BANKS-1:0] v);
        logic [BC_W-1:0] c;
        c = '0;
        for (int i = 0; i < NUM_BANKS; i++) begin
            c = c + BC_W'(v[i]);
        end
        return c;
    endfunction

    // Stage 0: combinational event vectors formed at the inputs
    logic [NUM_REQS-1:0]  rd_p0, wr_p0, cs_p0;
    logic [NUM_BANKS-1:0] rm_p0, wm_p0, bs_p0, ms_p0;
    logic                 mm_p0;

    assign rd_p0 = core_req_valid & core_req_ready & ~core_req_rw;
    assign wr_p0 = core_req_valid & core_req_ready & core_req_rw;
    assign cs_p0 = core_rsp_valid & ~core_rsp_ready;
    assign rm_p0 = bank_miss_valid & ~bank_miss_rw;
    assign wm_p0 = bank_miss_valid & bank_miss_rw;
    assign bs_p0 = bank_stall;
    assign ms_p0 = mshr_stall;
    assign mm_p0 = mem_req_valid & ~mem_req_ready;

    // Stage 1: gated event registers; clear also flushes them so no stale cycle leaks through
    logic [NUM_REQS-1:0]  rd_p1, wr_p1, cs_p1;
    logic [NUM_BANKS-1:0] rm_p1, wm_p1, bs_p1, ms_p1;
    logic                 mm_p1;

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            rd_p1 <= '0;
            wr_p1 <= '0;
            cs_p1 <= '0;
            rm_p1 <= '0;
            wm_p1 <= '0;
            bs_p1 <= '0;
            ms_p1 <= '0;
            mm_p1 <= 1'b0;
        end else begin
            rd_p1 <= rd_p0 & {NUM_REQS{enable}};
            wr_p1 <= wr_p0 & {NUM_REQS{enable}};
            cs_p1 <= cs_p0 & {NUM_REQS{enable}};
            rm_p1 <= rm_p0 & {NUM_BANKS{enable}};
            wm_p1 <= wm_p0 & {NUM_BANKS{enable}};
            bs_p1 <= bs_p0 & {NUM_BANKS{enable}};
            ms_p1 <= ms_p0 & {NUM_BANKS{enable}};
            mm_p1 <= mm_p0 & enable;
        end
    end

    // Stage 2: modulo-2^PERF_CTR_BITS accumulation, all counters in parallel
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            reads        <= '0;
            writes       <= '0;
            read_misses  <= '0;
            write_misses <= '0;
            bank_stalls  <= '0;
            mshr_stalls  <= '0;
            mem_stalls   <= '0;
            crsp_stalls  <= '0;
        end else begin
            reads        <= reads        + PERF_CTR_BITS'(pop_req(rd_p1));
            writes       <= writes       + PERF_CTR_BITS'(pop_req(wr_p1));
            crsp_stalls  <= crsp_stalls  + PERF_CTR_BITS'(pop_req(cs_p1));
            read_misses  <= read_misses  + PERF_CTR_BITS'(pop_bank(rm_p1));
            write_misses <= write_misses + PERF_CTR_BITS'(pop_bank(wm_p1));
            bank_stalls  <= bank_stalls  + PERF_CTR_BITS'(pop_bank(bs_p1));
            mshr_stalls  <= mshr_stalls  + PERF_CTR_BITS'(pop_bank(ms_p1));
            mem_stalls   <= mem_stalls   + PERF_CTR_BITS'(mm_p1);
        end
    end

endmodule

// File: tb/tb_cache_perf_collector.sv
// Directed bench for cache_perf_collector: a 44-bit instance for general behaviour
// and an 8-bit instance sharing the same inputs for counter wrap-around.
module tb_cache_perf_collector;

    localparam int NR = 4;
    localparam int NB = 2;
    localparam int CW = 44;
    localparam int WW = 8;

    logic clk = 1'b0;
    logic reset, enable, clear;
    logic [NR-1:0] core_req_valid, core_req_ready, core_req_rw;
    logic [NR-1:0] core_rsp_valid, core_rsp_ready;
    logic [NB-1:0] bank_miss_valid, bank_miss_rw, bank_stall, mshr_stall;
    logic mem_req_valid, mem_req_ready;

    logic [CW-1:0] reads, writes, read_misses, write_misses;
    logic [CW-1:0] bank_stalls, mshr_stalls, mem_stalls, crsp_stalls;
    logic [WW-1:0] w_reads, w_writes, w_read_misses, w_write_misses;
    logic [WW-1:0] w_bank_stalls, w_mshr_stalls, w_mem_stalls, w_crsp_stalls;

    int n_chk  = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    cache_perf_collector #(.NUM_REQS(NR), .NUM_BANKS(NB), .PERF_CTR_BITS(CW)) dut (
        .clk(clk), .reset(reset), .enable(enable), .clear(clear),
        .core_req_valid(core_req_valid), .core_req_ready(core_req_ready),
        .core_req_rw(core_req_rw), .core_rsp_valid(core_rsp_valid),
        .core_rsp_ready(core_rsp_ready), .bank_miss_valid(bank_miss_valid),
        .bank_miss_rw(bank_miss_rw), .bank_stall(bank_stall), .mshr_stall(mshr_stall),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
        .reads(reads), .writes(writes), .read_misses(read_misses),
        .write_misses(write_misses), .bank_stalls(bank_stalls),
        .mshr_stalls(mshr_stalls), .mem_stalls(mem_stalls), .crsp_stalls(crsp_stalls)
    );

    cache_perf_collector #(.NUM_REQS(NR), .NUM_BANKS(NB), .PERF_CTR_BITS(WW)) dut_wrap (
        .clk(clk), .reset(reset), .enable(enable), .clear(clear),
        .core_req_valid(core_req_valid), .core_req_ready(core_req_ready),
        .core_req_rw(core_req_rw), .core_rsp_valid(core_rsp_valid),
        .core_rsp_ready(core_rsp_ready), .bank_miss_valid(bank_miss_valid),
        .bank_miss_rw(bank_miss_rw), .bank_stall(bank_stall), .mshr_stall(mshr_stall),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
        .reads(w_reads), .writes(w_writes), .read_misses(w_read_misses),
        .write_misses(w_write_misses), .bank_stalls(w_bank_stalls),
        .mshr_stalls(w_mshr_stalls), .mem_stalls(w_mem_stalls), .crsp_stalls(w_crsp_stalls)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        enable = 1'b1; clear = 1'b0;
        core_req_valid = '0; core_req_ready = '0; core_req_rw = '0;
        core_rsp_valid = '0; core_rsp_ready = '0;
        bank_miss_valid = '0; bank_miss_rw = '0; bank_stall = '0; mshr_stall = '0;
        mem_req_valid = 1'b0; mem_req_ready = 1'b0;
    endtask

    task automatic do_reset();
        idle();
        reset = 1'b1;
        step();
        reset = 1'b0;
    endtask

    task automatic reads_only(input logic [NR-1:0] v);
        core_req_valid = v; core_req_ready = v; core_req_rw = '0;
    endtask

    initial begin
        idle();
        reset = 1'b1;
        // Reset held with random traffic on every input
        for (int i = 0; i < 3; i++) begin
            core_req_valid = NR'($urandom); core_req_ready = NR'($urandom);
            core_req_rw = NR'($urandom); core_rsp_valid = NR'($urandom);
            core_rsp_ready = NR'($urandom); bank_miss_valid = NB'($urandom);
            bank_miss_rw = NB'($urandom); bank_stall = NB'($urandom);
            mshr_stall = NB'($urandom); mem_req_valid = 1'($urandom);
            mem_req_ready = 1'($urandom); clear = 1'($urandom);
            enable = 1'($urandom);
            step();
            chk("rst_hold_all", 64'(reads | writes | read_misses | write_misses |
                bank_stalls | mshr_stalls | mem_stalls | crsp_stalls), 64'd0);
        end
        reset = 1'b0;
        idle();
        step();
        chk("rst_release_all", 64'(reads | writes | read_misses | write_misses |
            bank_stalls | mshr_stalls | mem_stalls | crsp_stalls), 64'd0);

        // Single mixed request cycle: 2 reads, 2 writes
        core_req_valid = 4'b1111; core_req_ready = 4'b1111; core_req_rw = 4'b0101;
        step();
        idle();
        chk("first_latency_reads", 64'(reads), 64'd0);
        step();
        chk("first_reads", 64'(reads), 64'd2);
        chk("first_writes", 64'(writes), 64'd2);

        // Full parallel load for 10 cycles
        do_reset();
        core_req_valid = '1; core_req_ready = '1; core_req_rw = 4'b0101;
        core_rsp_valid = '1; core_rsp_ready = '0;
        bank_miss_valid = '1; bank_miss_rw = 2'b01; bank_stall = '1; mshr_stall = '1;
        mem_req_valid = 1'b1; mem_req_ready = 1'b0;
        for (int k = 1; k <= 10; k++) begin
            step();
            if (k == 2) chk("full_k2_reads", 64'(reads), 64'd2);
        end
        idle();
        step();
        chk("full_reads", 64'(reads), 64'd20);
        chk("full_writes", 64'(writes), 64'd20);
        chk("full_rd_miss", 64'(read_misses), 64'd10);
        chk("full_wr_miss", 64'(write_misses), 64'd10);
        chk("full_bank_st", 64'(bank_stalls), 64'd20);
        chk("full_mshr_st", 64'(mshr_stalls), 64'd20);
        chk("full_mem_st", 64'(mem_stalls), 64'd10);
        chk("full_crsp_st", 64'(crsp_stalls), 64'd40);

        // Wrap-around on the 8-bit instance
        do_reset();
        reads_only(4'b0001);
        for (int i = 0; i < 254; i++) step();
        idle();
        step();
        chk("wrap_pre", 64'(w_reads), 64'd254);
        reads_only(4'b1111);
        step();
        idle();
        step();
        chk("wrap_post", 64'(w_reads), 64'd2);
        chk("wrap_wide_ref", 64'(reads), 64'd258);

        // Clear mid-stream with continuous 4 reads per cycle
        do_reset();
        reads_only(4'b1111);
        step(); step(); step();
        chk("clr_before", 64'(reads), 64'd8);
        clear = 1'b1;
        step();
        chk("clr_n1", 64'(reads), 64'd0);
        clear = 1'b0;
        step();
        chk("clr_n2", 64'(reads), 64'd0);
        step();
        chk("clr_n3", 64'(reads), 64'd4);
        step();
        chk("clr_n4", 64'(reads), 64'd8);

        // Enable gating
        do_reset();
        reads_only(4'b1111);
        enable = 1'b0;
        for (int i = 0; i < 5; i++) step();
        enable = 1'b1;
        for (int i = 0; i < 3; i++) step();
        idle();
        step(); step();
        chk("en_gate_reads", 64'(reads), 64'd12);
        reads_only(4'b1111);
        step();
        enable = 1'b0;
        step(); step();
        idle();
        step();
        chk("en_prev_cycle", 64'(reads), 64'd16);

        // Handshake filtering
        do_reset();
        core_req_valid = '1; core_req_ready = '0; core_req_rw = 4'b0101;
        core_rsp_valid = '1; core_rsp_ready = '1;
        mem_req_valid = 1'b1; mem_req_ready = 1'b1;
        bank_miss_valid = 2'b11; bank_miss_rw = 2'b10;
        step();
        idle();
        step();
        chk("hs_reads", 64'(reads), 64'd0);
        chk("hs_writes", 64'(writes), 64'd0);
        chk("hs_crsp", 64'(crsp_stalls), 64'd0);
        chk("hs_mem", 64'(mem_stalls), 64'd0);
        chk("hs_rd_miss", 64'(read_misses), 64'd1);
        chk("hs_wr_miss", 64'(write_misses), 64'd1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/cache_perf_collector.md
# cache_perf_collector

Per-cycle event accumulator feeding the cache performance-counter interface (`VX_perf_cache_if`, master side). It sits beside each cache instance and samples request/response handshakes and per-bank miss and stall strobes. It reduces them by population count through a registered pipeline and accumulates eight wrap-around counters. The counter outputs drive the interface's `reads`, `writes`, `read_misses`, `write_misses`, `bank_stalls`, `mshr_stalls`, `mem_stalls` and `crsp_stalls` signals.

## Interface
Parameters:
- NUM_REQS, 4, core request/response ports
- NUM_BANKS, 2, cache banks
- PERF_CTR_BITS, 44, counter width (matches `PERF_CTR_BITS`)

Ports:
- clk  input  1  clock; the only clock
- reset  input  1  synchronous, active-high reset
- enable  input  1  1 = sample events; 0 = current cycle's events ignored
- clear  input  1  synchronous counter clear
- core_req_valid / core_req_ready / core_req_rw  input  NUM_REQS each  core request handshake; rw 1 = write
- core_rsp_valid / core_rsp_ready  input  NUM_REQS each  core response handshake
- bank_miss_valid / bank_miss_rw  input  NUM_BANKS each  one-cycle miss strobe per bank; rw 1 = write miss
- bank_stall  input  NUM_BANKS  bank-conflict stall strobe
- mshr_stall  input  NUM_BANKS  MSHR-full stall strobe
- mem_req_valid / mem_req_ready  input  1 each  memory request handshake
- reads, writes, read_misses, write_misses, bank_stalls, mshr_stalls, mem_stalls, crsp_stalls  output  PERF_CTR_BITS each  accumulated counts

## Operation
Event vectors, formed combinationally at the inputs:
- rd = core_req_valid & core_req_ready & ~core_req_rw
- wr = core_req_valid & core_req_ready & core_req_rw
- rm = bank_miss_valid & ~bank_miss_rw
- wm = bank_miss_valid & bank_miss_rw
- bs = bank_stall
- ms = mshr_stall
- mm = mem_req_valid & ~mem_req_ready (1 bit)
- cs = core_rsp_valid & ~core_rsp_ready

Stage 1 (S1) registers:
- Register the eight vectors, each ANDed with `enable`.
- With enable=0, S1 loads zeros.

Stage 2 (counters):
- Each counter += popcount of its S1 vector.
- Popcount width is $clog2(N+1), zero-extended to PERF_CTR_BITS.
- Addition is modulo 2^PERF_CTR_BITS: wraps silently, no saturation, no overflow flag.
- All eight counters update independently in the same cycle; simultaneous events on every port are all counted.

reset or clear:
- S1 and all counters load 0 at that edge.
- Events sampled in that cycle are discarded; events held in S1 from the prior cycle are discarded.
- reset and clear are equivalent; clear has no effect beyond reset when both are asserted.

Counters are free-running and have no hold condition other than a zero-valued S1.

## Timing
- Reset value: all eight outputs 0; S1 all 0.
- Latency: an event sampled at rising edge N is reflected in the outputs after edge N+1 (visible in cycle N+2).
- Throughput: per counter, up to NUM_REQS or NUM_BANKS increments per cycle, every cycle.
- enable deasserted in cycle N: cycle-N events never counted; events from cycle N−1 still land at edge N.
- clear in cycle N: outputs are 0 in cycle N+1. Events in cycle N+1 appear in cycle N+3.
- Clear mid-stream with continuous traffic: the first post-clear nonzero value equals exactly the cycle N+1 event count.
- Outputs are registered; no combinational path from inputs to outputs.

## Test plan
- Reset: hold reset 3 cycles with all inputs toggling → every output 0 throughout and in the first cycle after release. Feed core_req_valid=ready=4'b1111, rw=4'b0101 for 1 cycle → reads=2, writes=2 two cycles later.
- Full parallel load: all strobes all-ones for 10 cycles, mem_req_valid=1, ready=0 → reads+writes=40, read_misses+write_misses=20, bank_stalls=20, mshr_stalls=20, mem_stalls=10, crsp_stalls=40 (rsp_ready=0).
- Wrap: PERF_CTR_BITS=8, preload reads to 254 via 254 single-port reads, then one cycle with 4 reads → reads=2.
- Clear mid-stream: 4 reads/cycle continuously, clear pulsed 1 cycle → outputs 0 the cycle after clear, then 4, 8, … with no stale S1 value counted.
- enable gating: enable=0 for 5 cycles of full traffic, then 1 for 3 cycles → reads=12 only. The cycle preceding the enable drop is still counted when present.
- Handshake filtering: valid=1, ready=0 on all req ports → reads=writes=0. bank_miss_valid=2'b11, rw=2'b10 → read_misses=1, write_misses=1.
